// File: rtl/alu_wb_return_pkg.sv
// Shared register-file constants and helpers for the ALU write-back return path.
// Holds the constants that decode, ALU and write-back must agree on.
package alu_wb_return_pkg;

   localparam int DATA_SIZE     = 32;
   localparam int REG_ADDR_SIZE = 5;
   localparam int WB_DEPTH      = 4;

   typedef logic [DATA_SIZE-1:0]     data_t;
   typedef logic [REG_ADDR_SIZE-1:0] reg_addr_t;

   localparam logic      REG_WRITE_ACCEPT = 1'b1;
   localparam logic      REG_WRITE_DENY   = 1'b0;
   localparam reg_addr_t REG_ADDR_RESET   = '0;
   localparam data_t     DATA_BUS_RESET   = '0;

   // x0 is hard-wired zero, so writes to it are discarded like denied writes.
   function automatic logic is_writable(input logic we, input reg_addr_t addr);
      return (we == REG_WRITE_ACCEPT) && (addr != '0);
   endfunction

endpackage

// File: rtl/alu_wb_return_if.sv
// ALU-result handshake, register-file write port and bypass lookup bundle.
interface alu_wb_return_if
   import alu_wb_return_pkg::*;
#(
   parameter int PTR_W = 2
);
   logic             validIn;
   logic             readyOut;
   logic             writeEnableIn;
   reg_addr_t        writeBackAddrIn;
   data_t            writeDataIn;
   logic             regWriteEnable;
   reg_addr_t        regWriteAddr;
   data_t            regWriteData;
   logic             regWriteReady;
   reg_addr_t        srcAddr1;
   reg_addr_t        srcAddr2;
   logic             fwdHit1;
   logic             fwdHit2;
   data_t            fwdData1;
   data_t            fwdData2;
   logic [PTR_W:0]   pendingCount;

   modport master (
      output validIn, writeEnableIn, writeBackAddrIn, writeDataIn,
      output regWriteReady, srcAddr1, srcAddr2,
      input  readyOut, regWriteEnable, regWriteAddr, regWriteData,
      input  fwdHit1, fwdHit2, fwdData1, fwdData2, pendingCount
   );

   modport slave (
      input  validIn, writeEnableIn, writeBackAddrIn, writeDataIn,
      input  regWriteReady, srcAddr1, srcAddr2,
      output readyOut, regWriteEnable, regWriteAddr, regWriteData,
      output fwdHit1, fwdHit2, fwdData1, fwdData2, pendingCount
   );

endinterface

// File: rtl/alu_wb_return_fwd_match.sv
// Newest-first bypass search over the pending write-back entries for one source.
module wb_fwd_match
   import alu_wb_return_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int PTR_W = 2
) (
   input  reg_addr_t [DEPTH-1:0] ent_addr,
   input  data_t     [DEPTH-1:0] ent_data,
   input  logic      [DEPTH-1:0] ent_vld,
   input  logic      [PTR_W-1:0] wr_ptr,
   input  reg_addr_t             src_addr,
   output logic                  hit,
   output data_t                 data
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to newest starting at wr_ptr; later matches overwrite earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = wr_ptr + PTR_W'(i);
         if (ent_vld[idx] && (ent_addr[idx] == src_addr) && (src_addr != '0)) begin
            hit  = 1'b1;
            data = ent_data[idx];
         end
      end
   end

endmodule

// File: rtl/alu_wb_return.sv
// In-order write-back buffer between the ALU and the register file,
// with a two-port bypass lookup over the pending entries.
module alu_wb_return
   import alu_wb_return_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int PTR_W = 2
) (
   input logic            clk,
   input logic            resetIn,
   alu_wb_return_if.slave wb
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   reg_addr_t [DEPTH-1:0] ent_addr;
   data_t     [DEPTH-1:0] ent_data;
   logic      [DEPTH-1:0] ent_vld;
   logic      [PTR_W-1:0] wr_ptr;
   logic      [PTR_W-1:0] rd_ptr;
   logic      [PTR_W:0]   count;
   logic                  ready;
   logic                  not_empty;
   logic                  push;
   logic                  pop;

   assign ready     = (count != FULL_CNT);
   assign not_empty = (count != '0);
   assign push      = wb.validIn && ready && is_writable(wb.writeEnableIn, wb.writeBackAddrIn);
   assign pop       = not_empty && wb.regWriteReady;

   always_ff @(posedge clk or negedge resetIn) begin
      if (!resetIn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ent_vld <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + (PTR_W+1)'(1);
         else if (pop && !push) count <= count - (PTR_W+1)'(1);
         // wr_ptr == rd_ptr only when empty or full, so push and pop never hit the same slot.
         if (pop)  ent_vld[rd_ptr] <= 1'b0;
         if (push) ent_vld[wr_ptr] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[wr_ptr] <= wb.writeBackAddrIn;
         ent_data[wr_ptr] <= wb.writeDataIn;
      end
   end

   assign wb.readyOut       = ready;
   assign wb.regWriteEnable = not_empty;
   assign wb.regWriteAddr   = not_empty ? ent_addr[rd_ptr] : REG_ADDR_RESET;
   assign wb.regWriteData   = not_empty ? ent_data[rd_ptr] : DATA_BUS_RESET;
   assign wb.pendingCount   = count;

   wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd1 (
      .ent_addr (ent_addr),
      .ent_data (ent_data),
      .ent_vld  (ent_vld),
      .wr_ptr   (wr_ptr),
      .src_addr (wb.srcAddr1),
      .hit      (wb.fwdHit1),
      .data     (wb.fwdData1)
   );

   wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd2 (
      .ent_addr (ent_addr),
      .ent_data (ent_data),
      .ent_vld  (ent_vld),
      .wr_ptr   (wr_ptr),
      .src_addr (wb.srcAddr2),
      .hit      (wb.fwdHit2),
      .data     (wb.fwdData2)
   );

endmodule
